// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI IMU read engine: FSM states,
// IMU register addresses and the mode-3 SCLK idle level.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT_ADDR,
    ST_SHIFT_DATA,
    ST_CS_HOLD,
    ST_CS_GAP
  } state_t;

  localparam logic [7:0] IMU_REG_ACCEL_X = 8'hA2;
  localparam logic [7:0] IMU_REG_ACCEL_Y = 8'hA4;
  localparam logic [7:0] IMU_REG_ACCEL_Z = 8'hA6;
  localparam logic [7:0] IMU_REG_GYRO_X  = 8'hA8;
  localparam logic [7:0] IMU_REG_GYRO_Y  = 8'hAA;
  localparam logic [7:0] IMU_REG_GYRO_Z  = 8'hAC;

  localparam logic SCLK_IDLE = 1'b1;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK phase divider: toggles sclk every CLK_DIV clk cycles while enabled,
// and parks sclk at its idle level with the phase cleared when disabled.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  always_comb begin
    wrap    = (phase_q == PH_LAST);
    phase_d = '0;
    sclk_d  = SCLK_IDLE;
    if (en) begin
      phase_d = wrap ? '0 : phase_q + 1'b1;
      sclk_d  = wrap ? ~sclk_q : sclk_q;
    end
  end

  // Ticks announce the transition that the coming clk edge will make on sclk.
  assign fall_tick = en && wrap && sclk_q;
  assign rise_tick = en && wrap && !sclk_q;
  assign sclk      = sclk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      sclk_q  <= SCLK_IDLE;
    end else begin
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_imu_reader.sv
// SPI mode-3 read engine: shifts out one address byte, reads back 0-2 data
// bytes little-endian. Define SPI_SIGN_EXTEND_EN to sign-extend 1-byte reads.
module spi_imu_reader
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  addr,
  input  logic [1:0]  rx_count,
  output logic        busy,
  output logic        byte_ack,
  output logic        done,
  output logic [15:0] data,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] WAIT_LAST = PW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [6:0]    rx_sh_q, rx_sh_d;
  logic [1:0]    n_q, n_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] wait_q, wait_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          byte_ack_q, byte_ack_d;
  logic          done_q, done_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic [15:0]   data_q, data_d;

  logic          clk_en, fall_tick, rise_tick, sclk_int, wait_wrap;
  logic [7:0]    rx_byte;

  function automatic logic [1:0] clamp_count(input logic [1:0] c);
    return (c == 2'd3) ? 2'd2 : c;
  endfunction

  // last_q stops the divider so sclk stays high through the final bit's high half.
  assign clk_en = (state_q == ST_CS_SETUP || state_q == ST_SHIFT_ADDR ||
                   state_q == ST_SHIFT_DATA) && !last_q;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (clk_en),
    .sclk     (sclk_int),
    .fall_tick(fall_tick),
    .rise_tick(rise_tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    n_d        = n_q;
    bit_cnt_d  = bit_cnt_q;
    wait_d     = '0;
    last_d     = last_q;
    busy_d     = busy_q;
    byte_ack_d = 1'b0;
    done_d     = 1'b0;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    data_d     = data_q;
    rx_byte    = {rx_sh_q, miso};
    wait_wrap  = (wait_q == WAIT_LAST);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CS_SETUP;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          tx_sh_d   = addr;
          n_d       = clamp_count(rx_count);
          bit_cnt_d = '0;
          last_d    = 1'b0;
        end
      end
      ST_CS_SETUP: begin
        if (fall_tick) begin
          state_d = ST_SHIFT_ADDR;
          mosi_d  = tx_sh_q[7];
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
      ST_SHIFT_ADDR, ST_SHIFT_DATA: begin
        if (last_q) begin
          wait_d = wait_q + 1'b1;
          if (wait_wrap) begin
            state_d = ST_CS_HOLD;
            wait_d  = '0;
          end
        end else if (fall_tick) begin
          // Address bits are exhausted by the data phase, so mosi reads back zeros.
          mosi_d  = tx_sh_q[7];
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end else if (rise_tick) begin
          rx_sh_d   = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (state_q == ST_SHIFT_ADDR) begin
            if (bit_cnt_q == 5'd7) begin
              if (n_q == 2'd0) last_d = 1'b1;
              else             state_d = ST_SHIFT_DATA;
            end
          end else if (bit_cnt_q[2:0] == 3'd7) begin
            byte_ack_d = 1'b1;
            if (bit_cnt_q == 5'd15) begin
              data_d[7:0] = rx_byte;
              if (n_q == 2'd1) begin
                last_d = 1'b1;
`ifdef SPI_SIGN_EXTEND_EN
                data_d[15:8] = {8{rx_byte[7]}};
`else
                data_d[15:8] = 8'h00;
`endif
              end
            end else begin
              data_d[15:8] = rx_byte;
              last_d       = 1'b1;
            end
          end
        end
      end
      ST_CS_HOLD: begin
        wait_d = wait_q + 1'b1;
        if (wait_wrap) begin
          state_d = ST_CS_GAP;
          wait_d  = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      ST_CS_GAP: begin
        wait_d = wait_q + 1'b1;
        if (wait_wrap) begin
          state_d = ST_IDLE;
          wait_d  = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      n_q        <= '0;
      bit_cnt_q  <= '0;
      wait_q     <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      byte_ack_q <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      n_q        <= n_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_q     <= wait_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      byte_ack_q <= byte_ack_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      data_q     <= data_d;
    end
  end

  assign busy     = busy_q;
  assign byte_ack = byte_ack_q;
  assign done     = done_q;
  assign data     = data_q;
  assign sclk     = sclk_int;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_imu_reader.sv
// Scoreboard bench for spi_imu_reader: directed transactions push expected
// results; a negedge monitor models the IMU slave and checks each done.
module tb_spi_imu_reader;
  import spi_pkg::*;

  localparam int CLK_DIV = 4;
`ifdef SPI_SIGN_EXTEND_EN
  localparam logic [15:0] EXP_B = 16'hFF85;
`else
  localparam logic [15:0] EXP_B = 16'h0085;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [1:0]  rx_count = 2'd0;
  logic        miso = 1'b0;
  logic        busy, byte_ack, done, sclk, mosi, cs_n;
  logic [15:0] data;

  spi_imu_reader #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rx_count(rx_count),
    .busy(busy), .byte_ack(byte_ack), .done(done), .data(data),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] data;
    int          done_rel;
    int          falls;
    int          acks;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] slave_data = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [15:0] d, input int dr,
                          input int fl, input int ak);
    exp_t e;
    e.a = a; e.data = d; e.done_rel = dr; e.falls = fl; e.acks = ak;
    q.push_back(e);
  endtask

  task automatic wait_idle(input int lim);
    for (int k = 0; k < lim && busy; k++) @(negedge clk);
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles", busy, lim);
    end
    @(negedge clk);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [1:0] rc, input logic [15:0] sd,
                         input logic [15:0] ed, input int dr, input int fl, input int ak);
    push_exp(a, ed, dr, fl, ak);
    slave_data = sd;
    @(negedge clk);
    addr = a; rx_count = rc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; addr = 8'hFF; rx_count = 2'd0;
    wait_idle(600);
  endtask

  // Monitor and IMU slave model
  int         cyc = 0, start_cyc = 0, falls = 0, rises = 0, acks = 0;
  int         cs_high_run = 0, exp_busy_rel = 0;
  logic [7:0] mosi_sh = 8'h00;
  logic       tail_bad = 1'b0, prev_sclk = 1'b1, prev_busy = 1'b0;
  logic       wait_busy = 1'b0, had_txn = 1'b0;
  exp_t       cur;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      wait_busy = 1'b0;
      miso = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        start_cyc = cyc - 1;
        falls = 0; rises = 0; acks = 0; mosi_sh = 8'h00; tail_bad = 1'b0;
        if (had_txn) chk("cs_gap_min", 32'(cs_high_run >= CLK_DIV), 32'd1);
        had_txn = 1'b1;
      end
      if (prev_sclk && !sclk) begin
        if (falls >= 8) miso = slave_data[8 * ((falls - 8) / 8) + 7 - ((falls - 8) % 8)];
        else            miso = 1'b0;
        falls++;
      end
      if (!prev_sclk && sclk) begin
        if (rises < 8) mosi_sh = {mosi_sh[6:0], mosi};
        else if (mosi) tail_bad = 1'b1;
        rises++;
      end
      if (byte_ack) acks++;
      if (done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, expected none", cyc);
        end else begin
          cur = q.pop_front();
          chk("data", data, cur.data);
          chk("done_cycle", cyc - start_cyc, cur.done_rel);
          chk("sclk_falls", falls, cur.falls);
          chk("byte_acks", acks, cur.acks);
          chk("mosi_addr", mosi_sh, cur.a);
          chk("mosi_tail_zero", tail_bad, 1'b0);
          chk("cs_n_at_done", cs_n, 1'b1);
          wait_busy = 1'b1;
          exp_busy_rel = cur.done_rel + CLK_DIV;
        end
      end
      if (!busy && prev_busy && wait_busy) begin
        chk("busy_fall_cycle", cyc - start_cyc, exp_busy_rel);
        wait_busy = 1'b0;
      end
    end
    cs_high_run = cs_n ? cs_high_run + 1 : 0;
    prev_sclk = sclk;
    prev_busy = busy;
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_byte_ack", byte_ack, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", data, 16'h0000);
    chk("rst_sclk", sclk, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_cs_n", cs_n, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    run_txn(IMU_REG_ACCEL_Y, 2'd2, 16'h1234, 16'h1234, 201, 24, 2);
    run_txn(IMU_REG_ACCEL_X, 2'd1, 16'h0085, EXP_B,    137, 16, 1);
    run_txn(8'h0F,           2'd0, 16'hFFFF, EXP_B,     73,  8, 0);
    run_txn(IMU_REG_ACCEL_Z, 2'd3, 16'hC35A, 16'hC35A, 201, 24, 2);

    // start held through a transaction and its CS gap
    slave_data = 16'h2211;
    push_exp(IMU_REG_GYRO_Y, 16'h2211, 201, 24, 2);
    push_exp(IMU_REG_GYRO_Y, 16'h2211, 201, 24, 2);
    @(negedge clk);
    addr = IMU_REG_GYRO_Y; rx_count = 2'd2; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 600 && busy; k++) @(negedge clk);
    chk("held_first_ends", busy, 1'b0);
    @(negedge clk);
    chk("held_restart_first_idle", busy, 1'b1);
    start = 1'b0;
    wait_idle(600);

    // reset in the middle of the data phase
    slave_data = 16'hBBAA;
    @(negedge clk);
    addr = IMU_REG_GYRO_Z; rx_count = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", cs_n, 1'b1);
    chk("abort_sclk", sclk, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_data", data, 16'h0000);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_stays_idle", busy, 1'b0);

    run_txn(IMU_REG_GYRO_X, 2'd2, 16'hEFBE, 16'hEFBE, 201, 24, 2);

    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
